// File: rtl/msk_aes_output_collector_pkg.sv
// Shared definitions for the masked AES output collector.
//   AES_W  : AES-128 block width in bits
//   clog2  : ceiling log2, usable in parameter expressions
//   sh_idx : position of share j of bit i in a d-share bus (i*d + j)
package msk_aes_output_collector_pkg;

  localparam int AES_W = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int sh_idx(input int i, input int j, input int d);
    return i * d + j;
  endfunction

endpackage

// File: rtl/msk_aes_output_collector_unmask.sv
// msk_unmask: recombines a d-share bus into plain bits.
//   in_sh     : count*d shared bits, share j of bit i at i*d+j
//   out_plain : count plain bits, out_plain[i] = XOR over j of in_sh[i*d+j]
// This is the only place where shares of a bit are combined.
module msk_unmask
  import msk_aes_output_collector_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = AES_W
) (
  input  logic [count*d-1:0] in_sh,
  output logic [count-1:0]   out_plain
);

  always_comb begin
    out_plain = '0;
    for (int i = 0; i < count; i++) begin
      for (int j = 0; j < d; j++) begin
        out_plain[i] = out_plain[i] ^ in_sh[sh_idx(i, j, d)];
      end
    end
  end

endmodule

// File: rtl/msk_aes_output_collector.sv
// msk_aes_output_collector: captures shared AES ciphertext pulses into a
// DEPTH-entry masked FIFO, presents the head entry over valid/ready in shared
// and unmasked form, and grants launch credits to the upstream core.
//   clk, nrst        : clock, synchronous active-low reset
//   clear            : synchronous flush (storage contents kept)
//   issue            : upstream launched one encryption
//   issue_allow      : a buffer slot is guaranteed for another launch
//   in_valid/in_sh_ct: ciphertext pulse and its shared value
//   ct_valid/ct_ready: head entry handshake
//   ct_sh/ct_data    : head entry, shared and recombined
//   count            : occupied entries
//   overflow         : sticky drop / credit protocol error flag
module msk_aes_output_collector
  import msk_aes_output_collector_pkg::*;
#(
  parameter int d     = 2,
  parameter int DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            clear,
  input  logic                            issue,
  output logic                            issue_allow,
  input  logic                            in_valid,
  input  logic [AES_W*d-1:0]              in_sh_ct,
  output logic                            ct_valid,
  input  logic                            ct_ready,
  output logic [AES_W*d-1:0]              ct_sh,
  output logic [AES_W-1:0]                ct_data,
  output logic [clog2(DEPTH+1)-1:0]       count,
  output logic                            overflow
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int SW = AES_W * d;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [SW-1:0] mem_q [DEPTH];
  logic [SW-1:0] mem_d [DEPTH];

  logic pop, push;

  assign ct_valid = (count_q != '0);
  assign pop      = ct_valid & ct_ready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push     = in_valid & ((count_q < DEPTH_C) | pop);

  always_comb begin
    count_d    = count_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;

    if (clear) begin
      count_d    = '0;
      inflight_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      // Popped entry is scrubbed; a push to the same slot below overrides it.
      if (pop) begin
        mem_d[rd_ptr_q] = '0;
        rd_ptr_d        = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push) begin
        mem_d[wr_ptr_q] = in_sh_ct;
        wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end else if (in_valid) begin
        overflow_d = 1'b1;
      end

      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      if (issue && !in_valid) begin
        if (inflight_q < DEPTH_C) inflight_d = inflight_q + 1'b1;
        else                      overflow_d = 1'b1;
      end else if (in_valid && !issue) begin
        if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      count_q    <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
    end
  end

  // Credits count both stored and still-in-flight results; widened to avoid wrap.
  assign issue_allow = ({1'b0, count_q} + {1'b0, inflight_q}) < {1'b0, DEPTH_C};
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign ct_sh       = mem_q[rd_ptr_q];

  msk_unmask #(
    .d     (d),
    .count (AES_W)
  ) u_unmask (
    .in_sh     (ct_sh),
    .out_plain (ct_data)
  );

endmodule

// File: tb/tb_msk_aes_output_collector.sv
module tb_msk_aes_output_collector;

  localparam int D     = 2;
  localparam int DEPTH = 2;

  typedef struct {
    logic [127:0] ct;
    logic [255:0] sh;
  } entry_t;

  logic         clk = 1'b0;
  logic         nrst, clear, issue, in_valid, ct_ready;
  logic         issue_allow, ct_valid, overflow;
  logic [255:0] in_sh_ct, ct_sh;
  logic [127:0] ct_data;
  logic [1:0]   count;

  int n_vec = 0;
  int n_err = 0;

  entry_t sb[$];
  int     m_inf;
  bit     m_ovf;
  bit     fix_a5 = 1'b0;

  always #5 clk = ~clk;

  msk_aes_output_collector #(.d(D), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .clear       (clear),
    .issue       (issue),
    .issue_allow (issue_allow),
    .in_valid    (in_valid),
    .in_sh_ct    (in_sh_ct),
    .ct_valid    (ct_valid),
    .ct_ready    (ct_ready),
    .ct_sh       (ct_sh),
    .ct_data     (ct_data),
    .count       (count),
    .overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] mk_sh(input logic [127:0] ct, input logic [127:0] m);
    logic [255:0] s;
    for (int i = 0; i < 128; i++) begin
      s[2*i]   = m[i];
      s[2*i+1] = ct[i] ^ m[i];
    end
    return s;
  endfunction

  task automatic check_state();
    int  sum;
    sum = sb.size() + m_inf;
    chk("count",       256'(count),       256'(sb.size()));
    chk("ct_valid",    256'(ct_valid),    256'(sb.size() != 0));
    chk("overflow",    256'(overflow),    256'(m_ovf));
    chk("issue_allow", 256'(issue_allow), 256'(sum < DEPTH));
    if (sb.size() != 0) begin
      chk("head_data", 256'(ct_data), 256'(sb[0].ct));
      chk("head_sh",   ct_sh,         sb[0].sh);
    end
  endtask

  // One clock cycle: drive inputs, update the model, pop-compare pre-edge.
  task automatic step(input bit iss, input bit iv, input logic [127:0] ct,
                      input bit rdy, input bit clr);
    entry_t e, h;
    bit     pop;
    e.ct     = ct;
    e.sh     = mk_sh(ct, fix_a5 ? {16{8'hA5}} : rnd128());
    issue    = iss;
    in_valid = iv;
    in_sh_ct = e.sh;
    ct_ready = rdy;
    clear    = clr;
    pop      = !clr && rdy && (sb.size() != 0);
    if (clr) begin
      sb.delete();
      m_inf = 0;
      m_ovf = 1'b0;
    end else begin
      if (pop) begin
        h = sb.pop_front();
        chk("pop_data", 256'(ct_data), 256'(h.ct));
        chk("pop_sh",   ct_sh,         h.sh);
      end
      if (iv) begin
        if (sb.size() < DEPTH) sb.push_back(e);
        else                   m_ovf = 1'b1;
      end
      if (iss && !iv) begin
        if (m_inf < DEPTH) m_inf++;
        else               m_ovf = 1'b1;
      end else if (iv && !iss) begin
        if (m_inf > 0) m_inf--;
      end
    end
    @(posedge clk); #1;
    issue = 0; in_valid = 0; ct_ready = 0; clear = 0;
    check_state();
  endtask

  task automatic do_reset(input int cycles);
    nrst = 0;
    repeat (cycles) @(posedge clk);
    #1 nrst = 1;
    sb.delete();
    m_inf = 0;
    m_ovf = 1'b0;
    chk("rst_count",   256'(count),       256'(0));
    chk("rst_valid",   256'(ct_valid),    256'(0));
    chk("rst_ovf",     256'(overflow),    256'(0));
    chk("rst_allow",   256'(issue_allow), 256'(1));
    chk("rst_ct_sh",   ct_sh,             256'(0));
    chk("rst_ct_data", 256'(ct_data),     256'(0));
  endtask

  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    nrst = 0; clear = 0; issue = 0; in_valid = 0; ct_ready = 0; in_sh_ct = '0;
    m_inf = 0; m_ovf = 0;
    @(posedge clk); #1;

    // 1: reset then idle
    do_reset(2);
    step(0, 0, '0, 0, 0);

    // 2: single result with fixed A5 mask
    step(1, 0, '0, 0, 0);
    repeat (50) step(0, 0, '0, 0, 0);
    fix_a5 = 1'b1;
    step(0, 1, CT0, 0, 0);
    fix_a5 = 1'b0;
    chk("t2_data", 256'(ct_data), 256'(CT0));
    step(0, 0, '0, 1, 0);
    chk("t2_zero_sh",   ct_sh,         256'(0));
    chk("t2_zero_data", 256'(ct_data), 256'(0));

    // 3: backpressure, overflow on third pulse, in-order drain
    step(1, 0, '0, 0, 0);
    step(0, 1, 128'h11112222333344445555666677778888, 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 1, 128'hdeadbeefcafef00d0123456789abcdef, 0, 0);
    step(0, 1, 128'hffffffffffffffffffffffffffffffff, 0, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 1);

    // 4: full with simultaneous push and pop, pointer wrap
    step(0, 1, 128'h0f0e0d0c0b0a09080706050403020100, 0, 0);
    step(0, 1, 128'h00112233445566778899aabbccddeeff, 0, 0);
    step(0, 1, 128'h3243f6a8885a308d313198a2e0370734, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    for (int k = 0; k < 6; k++) step(0, 1, rnd128(), 1, 0);
    step(0, 0, '0, 1, 0);

    // 5: credits
    step(0, 1, 128'ha5a5a5a5000000005a5a5a5affffffff, 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 1, 128'h39255a7dc7c2c1ad1b8aa5c47bb0f1f1, 0, 0);
    step(0, 0, '0, 1, 0);
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 0, 1);

    // 6: flush and reset mid-operation
    step(0, 1, 128'h0123456789abcdeffedcba9876543210, 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 1, 1);
    step(1, 0, '0, 0, 0);
    step(0, 1, 128'hcafebabe12345678cafebabe87654321, 0, 0);
    step(1, 0, '0, 0, 0);
    do_reset(1);
    step(1, 0, '0, 0, 0);
    step(0, 1, rnd128(), 0, 0);
    step(0, 0, '0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
